distram_req_ctrl: RTL and testbench

- Request/response front-end for the bit-write-enable distributed-RAM wrapper `xpm_sp_distram`.
- Accepts valid/ready memory requests with byte enables and expands them to the RAM's bit-wise `we`.
- Tracks the RAM's fixed 1-cycle read latency and buffers results in a response FIFO, so the consumer may apply backpressure.
- Every request, read or write, returns exactly one response in order. A write returns the pre-write word, because the RAM is read_first.

---
 rtl/distram_req_ctrl.sv | 116 +++++++++++
 tb/tb_distram_req_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/distram_req_ctrl.sv
// Valid/ready request front-end for a read-first bit-write-enable distributed RAM.
// Tracks the 1-cycle read latency and queues every response (read data or pre-write data).
module distram_req_ctrl #(
  parameter int unsigned MEM_DATAWIDTH = 128,
  parameter int unsigned MEM_ADDRWIDTH = 14,
  parameter int unsigned TAG_WIDTH     = 4,
  parameter int unsigned RSP_DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [MEM_DATAWIDTH/8-1:0] req_be,
  input  logic [MEM_ADDRWIDTH-1:0]   req_addr,
  input  logic [MEM_DATAWIDTH-1:0]   req_data,
  input  logic [TAG_WIDTH-1:0]       req_tag,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [MEM_DATAWIDTH-1:0]   rsp_data,
  output logic                       rsp_we,
  output logic [TAG_WIDTH-1:0]       rsp_tag,
  output logic                       mem_en,
  output logic [MEM_DATAWIDTH-1:0]   mem_we,
  output logic [MEM_ADDRWIDTH-1:0]   mem_addr,
  output logic [MEM_DATAWIDTH-1:0]   mem_din,
  input  logic [MEM_DATAWIDTH-1:0]   mem_dout
);

  localparam int unsigned BeW  = MEM_DATAWIDTH / 8;
  localparam int unsigned PtrW = $clog2(RSP_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic                 acc;
  logic                 push;
  logic                 pop;
  logic [CntW-1:0]      occ;

  logic                 infl_v_q, infl_v_d;
  logic                 infl_we_q, infl_we_d;
  logic [TAG_WIDTH-1:0] infl_tag_q, infl_tag_d;

  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic [MEM_DATAWIDTH-1:0] fifo_data_q [RSP_DEPTH];
  logic                     fifo_we_q   [RSP_DEPTH];
  logic [TAG_WIDTH-1:0]     fifo_tag_q  [RSP_DEPTH];

  // The in-flight slot is reserved up front, so the unconditional push never overflows.
  assign occ       = cnt_q + CntW'(infl_v_q);
  assign req_ready = (occ < CntW'(RSP_DEPTH)) & ~reset;
  assign acc       = req_valid & req_ready;

  assign mem_en   = acc;
  assign mem_addr = req_addr;
  assign mem_din  = req_data;

  always_comb begin
    mem_we = '0;
    for (int unsigned b = 0; b < BeW; b++) begin
      mem_we[b*8 +: 8] = {8{acc & req_we & req_be[b]}};
    end
  end

  assign push      = infl_v_q;
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = fifo_data_q[rd_ptr_q];
  assign rsp_we    = fifo_we_q[rd_ptr_q];
  assign rsp_tag   = fifo_tag_q[rd_ptr_q];

  always_comb begin
    infl_v_d   = acc;
    infl_we_d  = acc ? req_we : infl_we_q;
    infl_tag_d = acc ? req_tag : infl_tag_q;
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    cnt_d      = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      infl_v_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      infl_v_q <= infl_v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    infl_we_q  <= infl_we_d;
    infl_tag_q <= infl_tag_d;
  end

  // Payload storage needs no reset; validity lives entirely in the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= mem_dout;
      fifo_we_q[wr_ptr_q]   <= infl_we_q;
      fifo_tag_q[wr_ptr_q]  <= infl_tag_q;
    end
  end

endmodule

// File: tb/tb_distram_req_ctrl.sv
// Scoreboard bench for distram_req_ctrl: a behavioural RAM, a word-array reference model
// and a monitor that checks every presented response against the expected queue.
module tb_distram_req_ctrl;

  localparam int DW    = 128;
  localparam int AW    = 14;
  localparam int TW    = 4;
  localparam int DEPTH = 4;
  localparam int BW    = DW / 8;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [BW-1:0] req_be;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [TW-1:0] req_tag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_we;
  logic [TW-1:0] rsp_tag;
  logic          mem_en;
  logic [DW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  distram_req_ctrl #(
    .MEM_DATAWIDTH(DW),
    .MEM_ADDRWIDTH(AW),
    .TAG_WIDTH    (TW),
    .RSP_DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_be   (req_be),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_tag  (req_tag),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_we   (rsp_we),
    .rsp_tag  (rsp_tag),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-first RAM with bit write enables and a resettable output register.
  logic [DW-1:0] ram [1<<AW];
  bit            ram_inited;
  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
      ram_inited <= 1'b1;
    end
    if (reset) mem_dout <= '0;
    else if (mem_en) mem_dout <= ram[mem_addr];
    if (mem_en) ram[mem_addr] <= (ram[mem_addr] & ~mem_we) | (mem_din & mem_we);
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          we;
    logic [TW-1:0] tag;
    int            cyc;
    bit            exact;
  } exp_t;

  logic [DW-1:0] ref_mem [1<<AW];
  exp_t          exp_q[$];
  int            checks;
  int            failures;
  bit            always_rdy;
  bit            rand_rdy;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_accept(input bit we, input logic [BW-1:0] be, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input logic [TW-1:0] tag);
    logic [DW-1:0] old;
    logic [DW-1:0] mask;
    old  = ref_mem[addr];
    mask = '0;
    for (int b = 0; b < BW; b++) if (be[b]) mask[b*8 +: 8] = 8'hFF;
    if (we) ref_mem[addr] = (old & ~mask) | (data & mask);
    exp_q.push_back('{old, we, tag, cyc, always_rdy});
  endtask

  task automatic step(input bit v, input bit we, input logic [BW-1:0] be,
                      input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic [TW-1:0] tag, output bit acc);
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_data  = data;
    req_tag   = tag;
    if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    #1;
    acc = req_valid && req_ready;
    if (always_rdy && v) check("req_ready_sustained", DW'(req_ready), DW'(1));
    if (acc) model_accept(we, be, addr, data, tag);
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(1'b0, 1'b0, '0, '0, '0, '0, a);
  endtask

  task automatic issue(input bit we, input logic [BW-1:0] be, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [TW-1:0] tag);
    bit a;
    int n;
    n = 0;
    do begin
      step(1'b1, we, be, addr, data, tag, a);
      n++;
    end while (!a && n < 200);
    if (!a) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=not_accepted required=accepted addr=%h", addr);
    end
  endtask

  task automatic drain();
    int n;
    rand_rdy  = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      idle(1);
      n++;
    end
    idle(1);
    check("drain_outstanding", DW'(exp_q.size()), DW'(0));
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: every presented response must match the queue head; pop on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stale_rsp actual=rsp_valid tag=%h required=no_response", rsp_tag);
        end else begin
          e = exp_q[0];
          check("rsp_data", rsp_data, e.data);
          check("rsp_we", DW'(rsp_we), DW'(e.we));
          check("rsp_tag", DW'(rsp_tag), DW'(e.tag));
          if (rsp_ready) begin
            if (e.exact) check("rsp_latency", DW'(cyc - e.cyc), DW'(2));
            else check("rsp_latency_min", DW'(cyc - e.cyc >= 2), DW'(1));
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int n_acc;
    logic [DW-1:0] d;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_be = '0; req_addr = '0;
    req_data = '0; req_tag = '0; rsp_ready = 1'b1; always_rdy = 1'b0; rand_rdy = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("req_ready_in_reset", DW'(req_ready), DW'(0));
    check("mem_en_in_reset", DW'(mem_en), DW'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rsp_valid_after_reset", DW'(rsp_valid), DW'(0));
    check("req_ready_after_reset", DW'(req_ready), DW'(1));
    check("mem_en_idle", DW'(mem_en), DW'(0));
    check("mem_we_idle", mem_we, '0);

    // Full-word write then read, exact latency.
    always_rdy = 1'b1;
    issue(1'b1, '1, 14'h0010, 128'h0123456789ABCDEF0123456789ABCDEF, 4'd1);
    issue(1'b0, '0, 14'h0010, '0, 4'd2);
    idle(4);
    always_rdy = 1'b0;

    // Partial write, zero-byte-enable write, top address.
    issue(1'b1, '1, 14'd5, '1, 4'd3);
    issue(1'b1, 16'h0001, 14'd5, '0, 4'd4);
    issue(1'b0, '0, 14'd5, '0, 4'd5);
    issue(1'b1, '0, 14'd7, rnd_data(), 4'd6);
    issue(1'b0, '0, 14'd7, '0, 4'd7);
    issue(1'b1, '1, 14'h3FFF, rnd_data(), 4'd8);
    issue(1'b0, '0, 14'h3FFF, '0, 4'd9);
    drain();

    // Sustained throughput: 16 back-to-back reads.
    always_rdy = 1'b1;
    for (int i = 0; i < 16; i++) issue(1'b0, '0, AW'($urandom_range(0, 15)), '0, TW'(i));
    idle(4);
    always_rdy = 1'b0;
    drain();

    // Backpressure: exactly DEPTH accepts, then stall.
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, '0, AW'(i), '0, TW'(i), a);
      if (a) n_acc++;
    end
    check("bp_accepts", DW'(n_acc), DW'(DEPTH));
    check("bp_req_ready_low", DW'(req_ready), DW'(0));
    idle(5);
    drain();

    // Reset with two queued responses and one in flight.
    d = rnd_data();
    issue(1'b1, '1, 14'h0020, d, 4'hA);
    drain();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, '0, AW'(i), '0, TW'(i));
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    exp_q.delete();
    #1;
    check("req_ready_mid_reset", DW'(req_ready), DW'(0));
    check("mem_en_mid_reset", DW'(mem_en), DW'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rsp_valid_post_reset", DW'(rsp_valid), DW'(0));
    rsp_ready = 1'b1;
    idle(5);
    issue(1'b0, '0, 14'h0020, '0, 4'hB);
    issue(1'b0, '0, 14'h0010, '0, 4'hC);
    drain();

    // Randomized traffic with random backpressure and address collisions.
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom), BW'($urandom),
           ($urandom_range(0, 9) == 0) ? AW'((1 << AW) - 1) : AW'($urandom_range(0, 15)),
           rnd_data(), TW'($urandom), a);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
